// File: rtl/elliott_pkg.sv
// Shared types and layer defaults for the Elliott activation unit.
package elliott_pkg;

    typedef enum logic [1:0] {IDLE, DIV, POST} state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;

    // Fixed-point 1.0 for a given number of fractional bits.
    function automatic logic [64:0] frac_one(input int frac);
        return 65'd1 << frac;
    endfunction

endpackage

// File: rtl/elliott_frac_div.sv
// Serial restoring divider: q = floor(a * 2^FRAC / den), one bit per step, MSB first.
module elliott_frac_div #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH:0]   den,
    output logic [FRAC-1:0]  q,
    output logic             done
);

    localparam int CW = $clog2(FRAC + 1);

    logic [WIDTH+1:0] r;
    logic [WIDTH+1:0] r2;
    logic [WIDTH:0]   den_q;
    logic [CW-1:0]    cnt;
    logic             qbit;

    // r < den always holds, so 2r fits in WIDTH+2 bits.
    always_comb begin
        r2   = r << 1;
        qbit = (r2 >= {1'b0, den_q});
        done = step && (cnt == CW'(FRAC - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r     <= '0;
            den_q <= '0;
            q     <= '0;
            cnt   <= '0;
        end else if (load) begin
            r     <= {2'b00, a};
            den_q <= den;
            q     <= '0;
            cnt   <= '0;
        end else if (step) begin
            r   <= qbit ? (r2 - {1'b0, den_q}) : r2;
            q   <= FRAC'({q, qbit});
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/elliott_activation_seq.sv
// Sequential Elliott activation x/(1+|x|) or derivative 1/(1+|x|)^2 in Q-format fixed point.
module elliott_activation_seq
    import elliott_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic             mode,
    input  logic             start,
    output logic [WIDTH-1:0] y,
    output logic             end_signal,
    output logic             busy
);

    localparam logic [WIDTH:0]   ONE_W   = (WIDTH+1)'(frac_one(FRAC));
    localparam logic [FRAC:0]    ONE_F   = (FRAC+1)'(frac_one(FRAC));
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nx;
    logic             neg, mode_q;
    logic             load, step, div_done;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH:0]   den_in;
    logic [FRAC-1:0]  q;
    logic [WIDTH-1:0] q_ext, act, der, res;
    logic [FRAC:0]    m;
    logic [2*FRAC+1:0] mm;

    // |x| with the most negative code saturated to the largest positive one.
    always_comb begin
        a_in = x;
        if (x[WIDTH-1])
            a_in = (x == MIN_NEG) ? MAX_POS : -x;
        den_in = ONE_W + {1'b0, a_in};
    end

    elliott_frac_div #(.WIDTH(WIDTH), .FRAC(FRAC)) u_div (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .a     (a_in),
        .den   (den_in),
        .q     (q),
        .done  (div_done)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: if (start) begin
                load     = 1'b1;
                state_nx = DIV;
            end
            DIV: begin
                step = 1'b1;
                if (div_done) state_nx = POST;
            end
            POST:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // q < ONE, so 1-q is in 1..ONE and its square shifted back never exceeds ONE.
    always_comb begin
        q_ext = {{(WIDTH-FRAC){1'b0}}, q};
        act   = neg ? -q_ext : q_ext;
        m     = ONE_F - {1'b0, q};
        mm    = {{(FRAC+1){1'b0}}, m} * {{(FRAC+1){1'b0}}, m};
        der   = WIDTH'(mm >> FRAC);
        res   = mode_q ? der : act;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            y          <= '0;
            end_signal <= 1'b0;
            neg        <= 1'b0;
            mode_q     <= 1'b0;
        end else begin
            state      <= state_nx;
            end_signal <= (state == POST);
            if (load) begin
                neg    <= x[WIDTH-1];
                mode_q <= mode;
            end
            if (state == POST) y <= res;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/elliott_activation_seq.md
# elliott_activation_seq

Parametrised sequential Elliott activation unit for the neural-network datapath. Computes either the activation y = x/(1+|x|) or its derivative y = 1/(1+|x|)^2 on a signed fixed-point input. Uses a bit-serial fractional divider with a start/end_signal handshake. Sits between the neuron accumulator and the layer output register, and the derivative mode feeds back-propagation.

## Interface
- WIDTH, default 32: data width of x and y; signed two's complement; 8..64.
- FRAC, default 16: fractional bits, Q(WIDTH-FRAC-1).FRAC; 1 ≤ FRAC ≤ WIDTH-2.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on clk rising edge.
- x  in  WIDTH  signed operand; captured only when start is accepted.
- mode  in  1  0 = activation, 1 = derivative; captured with x.
- start  in  1  request pulse; accepted only in IDLE.
- y  out  WIDTH  signed result; held until next result.
- end_signal  out  1  one-cycle pulse; marks y as valid-new.
- busy  out  1  high in DIV and POST.

## Operation
- ONE = 2^FRAC.
- Capture: a = |x|. The most negative x saturates a to 2^(WIDTH-1)-1. Store neg = x[WIDTH-1] and mode.
- Denominator: den = ONE + a, unsigned WIDTH+1 bits, no overflow.
- Divide: restoring long division producing FRAC quotient bits, one bit per cycle.
  - Initial remainder r = a (always < den); width WIDTH+2.
  - Each step: r = 2r; if r ≥ den then r -= den and bit = 1, else bit = 0.
  - Bits shift MSB-first into q, FRAC bits. Then q = floor(a·ONE/den) < ONE.
- Post, activation mode: y = neg ? -q : q, sign-extended to WIDTH.
- Post, derivative mode: m = ONE - q (FRAC+1 bits, range 1..ONE); y = (m·m) >> FRAC, truncated, always ≥ 0. neg is ignored.
- States and transitions:
  - IDLE → DIV on start.
  - DIV → POST after FRAC steps.
  - POST → IDLE, writing y and pulsing end_signal.
- start while busy is ignored and is not queued.
- start high in the cycle end_signal is high is accepted, giving back-to-back operation.
- x and mode changes after acceptance do not affect the running operation.

## Timing
- Reset values: y = 0, end_signal = 0, busy = 0, state IDLE, internal q/r/neg/mode = 0.
- Edge 0: start sampled high in IDLE; operands captured; busy rises after this edge.
- Edges 1..FRAC: one quotient bit per edge.
- Edge FRAC+1: y registered, end_signal = 1, busy = 0.
- end_signal falls at edge FRAC+2 unless it is re-pulsed, which cannot happen earlier than FRAC+1 cycles later.
- Latency: FRAC+1 cycles from start edge to end_signal. Throughput: one result per FRAC+1 cycles.
- reset low at any edge, including mid-DIV or on the POST edge, takes priority. All values return to reset state, no end_signal is produced, and y is cleared.
- reset low together with start: start is ignored.

## Structure
- Shared package elliott_pkg:
  - state enum {IDLE, DIV, POST}.
  - ONE(FRAC) helper function.
  - Default WIDTH/FRAC localparams for the layer.
- Sub-module elliott_frac_div: serial restoring divider with load/step/done, parametrised WIDTH and FRAC. The top holds the FSM, abs/sign logic and the post-processing multiplier.
- A single WIDTH-wide multiplier is used only in POST; no pipelining required.

## Test plan
All cases use WIDTH=32, FRAC=16 unless stated.
- x=0x00000000, mode 0 → y=0x00000000; end_signal exactly 17 cycles after start edge, 1 cycle wide.
- x=0x00020000 (2.0) → 0x0000AAAA. x=0x00040000 (4.0) → 0x0000CCCC. x=0xFFFF0000 (-1.0) → 0xFFFF8000.
- x=0x80000000, mode 0 → 0xFFFF0002 (saturated |x|). Mode 1, x=0x00010000 → 0x00004000. Mode 1, x=0 → 0x00010000.
- start re-pulsed mid-DIV with x changed → ignored; result matches original x; only one end_signal.
- start held in end_signal cycle with x=2.0 after x=4.0 → 0xCCCC then 0xAAAA, with no idle gap.
- reset low at cycle 8 of DIV → y=0, busy=0, no end_signal; next start completes normally.
- Repeat the activation checks with WIDTH=16, FRAC=8 (x=0x0200 → 0x00AA); latency 9 cycles.
